conv_psum_accumulator: RTL

Downstream consumer of the 6-bit PIM convolution unit.
- Sequences the PIM crossbar address and compute-enable across all weight rows of one output pixel.
- Captures the 16-bit partial sum returned for each address and accumulates the sums into one wide result.
- Emits a shifted, saturated activation over a valid/ready handshake to the next layer.

---
 rtl/conv_psum_accumulator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/conv_psum_accumulator.sv
// Sweeps the PIM crossbar rows for one output pixel and accumulates the returned
// partial sums. The shifted, saturated activation is then offered over valid/ready.
module conv_psum_accumulator #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 24,
    parameter int NUM_ADDR = 16,
    parameter int PIM_LAT  = 2,
    parameter int SHIFT    = 4,
    parameter int OUT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    output logic [4:0]        pim_addr,
    output logic              pim_en,
    input  logic [DATA_W-1:0] pim_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              acc_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam logic [4:0]       LAST_ADDR   = 5'(NUM_ADDR - 1);
    localparam logic [ACC_W-1:0] ACC_MAX     = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] OUT_MAX_EXT = ACC_W'({OUT_W{1'b1}});

    // Returns {overflow, clamped sum}; the extra top bit of the sum is the carry.
    function automatic logic [ACC_W:0] sat_accumulate(
        input logic [ACC_W-1:0]  acc,
        input logic [DATA_W-1:0] data
    );
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W + 1)'(data);
        if (sum[ACC_W]) begin
            return {1'b1, ACC_MAX};
        end else begin
            return {1'b0, sum[ACC_W-1:0]};
        end
    endfunction

    function automatic logic [OUT_W-1:0] activation(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] shifted;
        shifted = acc >> SHIFT;
        if (shifted > OUT_MAX_EXT) begin
            return {OUT_W{1'b1}};
        end else begin
            return shifted[OUT_W-1:0];
        end
    endfunction

    state_e             state_q, state_d;
    logic [4:0]         addr_q, addr_d;
    logic               pim_en_q, pim_en_d;
    logic [PIM_LAT-1:0] vld_q, vld_d;
    logic [4:0]         resp_cnt_q, resp_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               acc_ovf_q, acc_ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               start_ready_q, start_ready_d;

    logic [PIM_LAT-1:0] vld_shift_s;
    logic               resp_hit_s;
    logic [ACC_W:0]     sat_s;

    // The tap of the tracking register is the pim_en seen by the PIM unit PIM_LAT cycles ago.
    if (PIM_LAT == 1) begin : g_lat_one
        assign vld_shift_s = pim_en_q;
    end else begin : g_lat_multi
        assign vld_shift_s = {vld_q[PIM_LAT-2:0], pim_en_q};
    end

    assign resp_hit_s = vld_q[PIM_LAT-1];
    assign sat_s      = sat_accumulate(acc_q, pim_data);

    // Next-state, sweep sequencing, response capture and output staging.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        pim_en_d      = pim_en_q;
        vld_d         = vld_shift_s;
        resp_cnt_d    = resp_cnt_q;
        acc_d         = acc_q;
        acc_ovf_d     = acc_ovf_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;

        if (resp_hit_s) begin
            acc_d      = sat_s[ACC_W-1:0];
            acc_ovf_d  = acc_ovf_q | sat_s[ACC_W];
            resp_cnt_d = resp_cnt_q + 5'd1;
        end else begin
            acc_d      = acc_q;
            acc_ovf_d  = acc_ovf_q;
            resp_cnt_d = resp_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d    = ISSUE;
                    pim_en_d   = 1'b1;
                    addr_d     = 5'd0;
                    acc_d      = {ACC_W{1'b0}};
                    acc_ovf_d  = 1'b0;
                    resp_cnt_d = 5'd0;
                end else begin
                    state_d  = IDLE;
                    pim_en_d = 1'b0;
                end
            end
            ISSUE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d  = DRAIN;
                    pim_en_d = 1'b0;
                    addr_d   = 5'd0;
                end else begin
                    pim_en_d = 1'b1;
                    addr_d   = addr_q + 5'd1;
                end
            end
            DRAIN: begin
                // The last response can only land here, so the output is built from acc_d.
                if (resp_hit_s && (resp_cnt_q == LAST_ADDR)) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = activation(acc_d);
                end else begin
                    state_d = DRAIN;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                pim_en_d    = 1'b0;
                addr_d      = 5'd0;
                out_valid_d = 1'b0;
            end
        endcase

        start_ready_d = (state_d == IDLE);
    end

    // State register; reset also drops any in-flight responses from the tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= 5'd0;
            pim_en_q      <= 1'b0;
            vld_q         <= {PIM_LAT{1'b0}};
            resp_cnt_q    <= 5'd0;
            acc_q         <= {ACC_W{1'b0}};
            acc_ovf_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= {OUT_W{1'b0}};
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            pim_en_q      <= pim_en_d;
            vld_q         <= vld_d;
            resp_cnt_q    <= resp_cnt_d;
            acc_q         <= acc_d;
            acc_ovf_q     <= acc_ovf_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            start_ready_q <= start_ready_d;
        end
    end

    assign start_ready = start_ready_q;
    assign pim_addr    = pim_addr_w();
    assign pim_en      = pim_en_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign acc_ovf     = acc_ovf_q;

    function automatic logic [4:0] pim_addr_w();
        return addr_q;
    endfunction

endmodule
